multi_input_rc_node: RTL

- Parametrised successor to the fixed-point single-node RC models used for discrete-circuit emulation, e.g. a 555 control-voltage node.
- Computes a first-order IIR node update with N_IN driving inputs: y[n] = sat((A*y[n-1] + Σ Bk*xk[n]) >> COEF_FRAC).
- Then produces a scaled output: v_out = sat((G*y) >> COEF_FRAC).
- Coefficients are runtime-programmable. A single time-multiplexed multiplier is used, with a valid/ready sample handshake. Sits between the sample-rate strobe generator and the audio mixer.

---
 rtl/multi_input_rc_node_if.sv | 27 ++
 rtl/multi_input_rc_node.sv | 130 +++++++++++++
 2 files changed

// File: rtl/multi_input_rc_node_if.sv
// Sample/coefficient/output bundle for the multi-input RC node.
interface multi_input_rc_node_if #(
  parameter int N_IN   = 3,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  logic                     sample_valid;
  logic                     sample_ready;
  logic [N_IN*DATA_W-1:0]   x_in;
  logic                     state_clr;
  logic                     coef_we;
  logic [3:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_wr_err;
  logic signed [DATA_W-1:0] v_out;
  logic                     out_valid;

  modport master (
    output sample_valid, x_in, state_clr, coef_we, coef_addr, coef_wdata,
    input  sample_ready, coef_wr_err, v_out, out_valid
  );

  modport slave (
    input  sample_valid, x_in, state_clr, coef_we, coef_addr, coef_wdata,
    output sample_ready, coef_wr_err, v_out, out_valid
  );
endinterface

// File: rtl/multi_input_rc_node.sv
// First-order IIR RC node with N_IN weighted inputs and scaled output,
// evaluated through one time-multiplexed signed multiplier.
module multi_input_rc_node #(
  parameter int N_IN      = 3,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 12,
  parameter int A_INIT    = 4091,
  parameter int G_INIT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multi_input_rc_node_if.slave   bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(N_IN + 1) + 1;
  localparam int N_COEF = N_IN + 2;
  localparam int CIDX_W = $clog2(N_COEF);
  localparam int XIDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [3:0]              ADDR_MAX = 4'(N_IN + 1);
  localparam logic [CIDX_W-1:0]       G_IDX    = CIDX_W'(N_IN + 1);
  localparam logic [CIDX_W-1:0]       LAST_MAC = CIDX_W'(N_IN);
  localparam logic signed [ACC_W-1:0] RND      =
    {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX  =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_ROUND, ST_SCALE} state_t;

  state_t                   r_state;
  logic [CIDX_W-1:0]        r_cnt;
  logic signed [COEF_W-1:0] r_coef [N_COEF];
  logic signed [DATA_W-1:0] r_x    [N_IN];
  logic signed [DATA_W-1:0] r_y;
  logic signed [DATA_W-1:0] r_vout;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic                     r_wr_err;

  logic                     w_idle;
  logic                     w_accept;
  logic                     w_wr_bad;
  logic                     w_wr_ok;
  logic [CIDX_W-1:0]        w_cidx;
  logic [XIDX_W-1:0]        w_xidx;
  logic signed [COEF_W-1:0] w_mul_a;
  logic signed [DATA_W-1:0] w_mul_b;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;

  function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = (v + RND) >>> COEF_FRAC;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[DATA_W-1:0];
  endfunction

  assign w_idle           = (r_state == ST_IDLE);
  assign bus.sample_ready = w_idle && !bus.state_clr;
  assign w_accept         = bus.sample_valid && bus.sample_ready;
  assign w_wr_bad         = bus.coef_we && (!w_idle || (bus.coef_addr > ADDR_MAX));
  assign w_wr_ok          = bus.coef_we && !w_wr_bad;

  // Coefficient bank index doubles as the MAC step: step 0 reads A, step k reads B(k-1).
  always_comb begin
    w_cidx  = (r_state == ST_SCALE) ? G_IDX : r_cnt;
    w_xidx  = (r_cnt == '0) ? '0 : XIDX_W'(r_cnt - 1'b1);
    w_mul_a = r_coef[w_cidx];
    w_mul_b = ((r_state == ST_MAC) && (r_cnt != '0)) ? r_x[w_xidx] : r_y;
  end

  assign w_prod     = w_mul_a * w_mul_b;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_y         <= '0;
      r_vout      <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_wr_err    <= 1'b0;
      for (int unsigned i = 0; i < N_COEF; i++) r_coef[i] <= '0;
      r_coef[0]     <= COEF_W'(A_INIT);
      r_coef[G_IDX] <= COEF_W'(G_INIT);
      for (int unsigned i = 0; i < N_IN; i++) r_x[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_wr_err    <= w_wr_bad;
      if (w_wr_ok) r_coef[bus.coef_addr[CIDX_W-1:0]] <= bus.coef_wdata;

      case (r_state)
        ST_IDLE: begin
          if (bus.state_clr) begin
            r_y <= '0;
          end else if (w_accept) begin
            for (int unsigned i = 0; i < N_IN; i++) r_x[i] <= bus.x_in[i*DATA_W +: DATA_W];
            r_cnt   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (r_cnt == '0) r_acc <= w_prod_ext;
          else             r_acc <= r_acc + w_prod_ext;
          if (r_cnt == LAST_MAC) r_state <= ST_ROUND;
          else                   r_cnt   <= r_cnt + 1'b1;
        end
        ST_ROUND: begin
          r_y     <= sat_round(r_acc);
          r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          r_vout      <= sat_round(w_prod_ext);
          r_out_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.v_out       = r_vout;
  assign bus.out_valid   = r_out_valid;
  assign bus.coef_wr_err = r_wr_err;
endmodule
